// File: rtl/nrz_symbol_mapper_if.sv
// Byte-stream handshake into the NRZ symbol mapper.
// The packet source is the master and the mapper is the slave.
interface nrz_symbol_mapper_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/nrz_symbol_mapper.sv
// Serializes bytes MSB-first into signed two-level NRZ samples (+LEVEL/-LEVEL).
// Each symbol is held for SPS sample ticks.
module nrz_symbol_mapper #(
  parameter int WIDTH = 16,
  parameter int LEVEL = 8192,
  parameter int SPS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_sample_en,
  nrz_symbol_mapper_if.slave      byte_bus,
  output logic signed [WIDTH-1:0] o_sample_out,
  output logic                    o_sample_valid,
  output logic                    o_busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0]          LAST_SAMP = CW'(SPS - 1);
  localparam logic signed [WIDTH-1:0] POS      = WIDTH'(LEVEL);
  localparam logic signed [WIDTH-1:0] NEG      = -POS;

  state_t                   r_state;
  logic [7:0]               r_hold;
  logic                     r_hold_full;
  logic [7:0]               r_shift;
  logic [2:0]               r_bit_cnt;
  logic [CW-1:0]            r_samp_cnt;
  logic signed [WIDTH-1:0]  r_sample_out;
  logic                     r_sample_valid;
  logic                     w_accept;

  assign w_accept            = byte_bus.data_valid && !r_hold_full;
  assign byte_bus.data_ready = !r_hold_full;
  assign o_busy              = r_hold_full || (r_state == SEND);
  assign o_sample_out        = r_sample_out;
  assign o_sample_valid      = r_sample_valid;

  // Accept and load test mutually exclusive hold_full values, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_hold         <= 8'd0;
      r_hold_full    <= 1'b0;
      r_shift        <= 8'd0;
      r_bit_cnt      <= 3'd0;
      r_samp_cnt     <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_accept) begin
        r_hold      <= byte_bus.data_in;
        r_hold_full <= 1'b1;
      end
      if (i_sample_en) begin
        r_sample_valid <= 1'b1;
        case (r_state)
          SEND: begin
            r_sample_out <= r_shift[7] ? POS : NEG;
            if (r_samp_cnt == LAST_SAMP) begin
              r_samp_cnt <= '0;
              r_shift    <= {r_shift[6:0], 1'b0};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7)
                r_state <= IDLE;
            end else begin
              r_samp_cnt <= r_samp_cnt + CW'(1);
            end
          end
          default: begin
            if (r_hold_full) begin
              r_hold_full  <= 1'b0;
              r_sample_out <= r_hold[7] ? POS : NEG;
              r_state      <= SEND;
              // With one sample per symbol, bit 7 is already complete on this tick.
              if (SPS == 1) begin
                r_shift    <= {r_hold[6:0], 1'b0};
                r_bit_cnt  <= 3'd1;
                r_samp_cnt <= '0;
              end else begin
                r_shift    <= r_hold;
                r_bit_cnt  <= 3'd0;
                r_samp_cnt <= CW'(1);
              end
            end else begin
              r_sample_out <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrz_symbol_mapper.sv
// Directed bench for nrz_symbol_mapper.
// dut4 runs at SPS=4 with a 1-in-5 sample strobe; dut1 runs at SPS=1 with a strobe on every clock.
module tb_nrz_symbol_mapper;
  localparam int POS = 8192;
  localparam int NEG = -8192;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] signs;
  } vec_t;

  logic clk;
  logic rst_n;
  logic en4, en1;
  bit   en4Run, en1Run;
  logic signed [15:0] out4, out1;
  logic valid4, valid1, busy4, busy1;

  int checks = 0;
  int errors = 0;

  int q4[$];
  bit busyQ4[$];
  int nz4 = 0;
  int q1nz[$];

  nrz_symbol_mapper_if bus4 ();
  nrz_symbol_mapper_if bus1 ();

  nrz_symbol_mapper #(.WIDTH(16), .LEVEL(8192), .SPS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_sample_en(en4), .byte_bus(bus4.slave),
    .o_sample_out(out4), .o_sample_valid(valid4), .o_busy(busy4));

  nrz_symbol_mapper #(.WIDTH(16), .LEVEL(8192), .SPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_sample_en(en1), .byte_bus(bus1.slave),
    .o_sample_out(out1), .o_sample_valid(valid1), .o_busy(busy1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobes change on the falling edge so they are stable at every rising edge.
  initial begin
    int cnt;
    cnt = 0;
    en4 = 1'b0;
    en1 = 1'b0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 5;
      en4 = en4Run && (cnt == 0);
      en1 = en1Run;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (valid4) begin
        q4.push_back(int'(out4));
        busyQ4.push_back(busy4);
        if (out4 != 16'sd0) nz4++;
      end
      if (valid1 && out1 != 16'sd0) q1nz.push_back(int'(out1));
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Presents a byte on the chosen port (0 = dut4, 1 = dut1); call at a falling edge.
  task automatic applyStimulus(input int port, input logic [7:0] d, input bit keep);
    int guard;
    guard = 0;
    if (port == 0) begin
      bus4.data_in = d;
      bus4.data_valid = 1'b1;
      while (!bus4.data_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      if (!keep) bus4.data_valid = 1'b0;
    end else begin
      bus1.data_in = d;
      bus1.data_valid = 1'b1;
      while (!bus1.data_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      if (!keep) bus1.data_valid = 1'b0;
    end
    if (guard >= 2000) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitSamples4(input int n, output bit ok);
    int c;
    c = 0;
    while (q4.size() < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    ok = (q4.size() >= n);
    if (!ok) checkOutput("sample_timeout", q4.size(), n);
  endtask

  function automatic int firstNonZero4();
    for (int i = 0; i < q4.size(); i++)
      if (q4[i] != 0) return i;
    return q4.size();
  endfunction

  vec_t vecs[5];

  initial begin
    bit ok;
    int st;
    int bad;
    logic [7:0] exp1[$];

    vecs[0] = '{8'hA5, 32'hF0F0_0F0F};
    vecs[1] = '{8'h80, 32'hF000_0000};
    vecs[2] = '{8'h3C, 32'h00FF_FF00};
    vecs[3] = '{8'h01, 32'h0000_000F};
    vecs[4] = '{8'h5A, 32'h0F0F_F0F0};

    rst_n = 1'b0;
    en4Run = 1'b1;
    en1Run = 1'b0;
    bus4.data_in = 8'h77;
    bus4.data_valid = 1'b1;
    bus1.data_in = 8'h00;
    bus1.data_valid = 1'b0;

    // Reset held with a valid byte on the bus: nothing may be captured.
    repeat (20) @(negedge clk);
    checkOutput("rst_sample_out", int'(out4), 0);
    checkOutput("rst_sample_valid", int'(valid4), 0);
    checkOutput("rst_busy", int'(busy4), 0);
    checkOutput("rst_ready", int'(bus4.data_ready), 1);
    bus4.data_valid = 1'b0;
    rst_n = 1'b1;
    q4.delete();
    busyQ4.delete();
    nz4 = 0;
    repeat (40) @(negedge clk);
    checkOutput("post_rst_busy", int'(busy4), 0);
    checkOutput("post_rst_nonzero", nz4, 0);
    checkOutput("post_rst_pulsing", int'(q4.size() >= 6), 1);

    for (int v = 0; v < 5; v++) begin
      q4.delete();
      busyQ4.delete();
      nz4 = 0;
      applyStimulus(0, vecs[v].data, 1'b0);
      waitSamples4(36, ok);
      if (ok) begin
        st = firstNonZero4();
        checkOutput($sformatf("v%0d_start", v), int'(st <= 1), 1);
        for (int k = 0; k < 32; k++)
          checkOutput($sformatf("v%0d_s%0d", v, k), q4[st + k], vecs[v].signs[31 - k] ? POS : NEG);
        checkOutput($sformatf("v%0d_idle0", v), q4[st + 32], 0);
        checkOutput($sformatf("v%0d_idle1", v), q4[st + 33], 0);
        checkOutput($sformatf("v%0d_busy31", v), int'(busyQ4[st + 30]), 1);
        checkOutput($sformatf("v%0d_busy32", v), int'(busyQ4[st + 31]), 0);
      end
    end

    // Back-to-back bytes with data_valid held high must stream without a gap.
    q4.delete();
    busyQ4.delete();
    nz4 = 0;
    applyStimulus(0, 8'hFF, 1'b1);
    checkOutput("ready_low_full", int'(bus4.data_ready), 0);
    applyStimulus(0, 8'h00, 1'b0);
    waitSamples4(68, ok);
    if (ok) begin
      st = firstNonZero4();
      checkOutput("gap_start", int'(st <= 1), 1);
      bad = 0;
      for (int k = 0; k < 64; k++)
        if (q4[st + k] != ((k < 32) ? POS : NEG)) bad++;
      checkOutput("gapless_bad_samples", bad, 0);
      checkOutput("gap_idle", q4[st + 64], 0);
    end

    // Reset in the middle of 0x3C with a second byte waiting in the hold register.
    q4.delete();
    busyQ4.delete();
    nz4 = 0;
    applyStimulus(0, 8'h3C, 1'b0);
    applyStimulus(0, 8'h99, 1'b0);
    begin
      int c;
      c = 0;
      while (nz4 < 10 && c < 2000) begin
        @(negedge clk);
        c++;
      end
    end
    checkOutput("mid_nonzero_count", nz4, 10);
    checkOutput("mid_busy", int'(busy4), 1);
    st = firstNonZero4();
    if (q4.size() >= st + 10) begin
      bad = 0;
      for (int k = 0; k < 10; k++)
        if (q4[st + k] != ((k < 8) ? NEG : POS)) bad++;
      checkOutput("mid_pre_reset_bad", bad, 0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out", int'(out4), 0);
    checkOutput("async_rst_valid", int'(valid4), 0);
    checkOutput("async_rst_busy", int'(busy4), 0);
    checkOutput("async_rst_ready", int'(bus4.data_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q4.delete();
    busyQ4.delete();
    nz4 = 0;
    repeat (100) @(negedge clk);
    checkOutput("after_rst_nonzero", nz4, 0);
    checkOutput("after_rst_busy", int'(busy4), 0);
    checkOutput("after_rst_pulsing", int'(q4.size() >= 15), 1);

    // SPS=1 stream of random bytes, sliced by sign.
    en1Run = 1'b1;
    q1nz.delete();
    @(negedge clk);
    for (int b = 0; b < 256; b++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      exp1.push_back(r);
      applyStimulus(1, r, 1'b0);
    end
    begin
      int c;
      c = 0;
      while (q1nz.size() < 2048 && c < 4000) begin
        @(negedge clk);
        c++;
      end
    end
    repeat (20) @(negedge clk);
    checkOutput("sps1_sample_count", q1nz.size(), 2048);
    if (q1nz.size() >= 2048) begin
      for (int b = 0; b < 256; b++) begin
        logic [7:0] got;
        got = 8'd0;
        for (int k = 0; k < 8; k++)
          got = {got[6:0], (q1nz[b * 8 + k] >= 0)};
        checkOutput($sformatf("sps1_byte%0d", b), int'(got), int'(exp1[b]));
      end
    end
    checkOutput("sps1_busy_end", int'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
